serial_addsub_unit: RTL and testbench
=====================================

SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

Interface
REQ-001 Parameter WORD_W, default 16, operand/result width in bits.
REQ-002 Parameter DIGIT_W, default 1, bits processed per clock; SHALL divide WORD_W exactly, else elaboration error.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  request new operation; sampled only in IDLE.
REQ-006 sub_i  input  1  0 = A+B, 1 = A-B; sampled with start_i.
REQ-007 a_i, b_i  input  WORD_W each  operands; sampled with start_i.
REQ-008 busy_o  output  1  high in RUN and DONE.
REQ-009 digit_o  output  DIGIT_W  current sum digit, LSB-first stream.
REQ-010 digit_vld_o  output  1  digit_o valid this cycle.
REQ-011 done_o  output  1  one-cycle pulse, result valid.
REQ-012 sum_o  output  WORD_W  result; held from done_o until next accepted start.
REQ-013 carry_o  output  1  final carry-out (sub: 1 = no borrow).
REQ-014 ovf_o  output  1  signed two's-complement overflow (see REQ-028).

Function
REQ-015 FSM states IDLE, RUN, DONE; N = WORD_W/DIGIT_W digits.
REQ-016 IDLE with start_i=1 at an edge SHALL load A, B (B inverted if sub_i), carry := sub_i, digit counter := 0, go to RUN.
REQ-017 start_i in RUN or DONE SHALL be ignored; operands unchanged.
REQ-018 Each RUN edge SHALL add low DIGIT_W bits of A, B and carry, shift A/B right by DIGIT_W, shift sum digit into result MSB end, update carry, increment counter.
REQ-019 digit_o/digit_vld_o SHALL be registered: digit k visible in the cycle after RUN edge k, digit_vld_o high for exactly N cycles.
REQ-020 On the RUN edge processing digit N-1, SHALL go to DONE; sum_o, carry_o, ovf_o updated, done_o=1 for the following cycle only.
REQ-021 Latency: done_o high exactly N+1 edges after the accepting edge (N processing edges plus start edge); DONE SHALL always return to IDLE on next edge.
REQ-022 Back-to-back: start_i asserted in the IDLE cycle after DONE SHALL be accepted; no throughput beyond one operation per N+2 cycles.
REQ-023 Arithmetic modulo 2^WORD_W; carry_o is bit WORD_W of A + (B or ~B) + sub_i.

Reset
REQ-024 reset SHALL force IDLE immediately; busy_o, done_o, digit_vld_o, digit_o, sum_o, carry_o, ovf_o all 0; internal carry/counter/shift registers 0.
REQ-025 reset mid-RUN SHALL abort operation; no done_o pulse for it, partial result discarded.
REQ-026 First start accepted on first edge after reset deasserts.

Configuration
REQ-027 Macro SERIAL_ADDSUB_OVF_EN controls overflow detection.
REQ-028 With SERIAL_ADDSUB_OVF_EN defined: ovf_o = carry into MSB XOR carry out of MSB, registered with sum_o. Without it: ovf_o tied 0, no overflow logic synthesised; port remains.

Structure
REQ-029 Package serial_addsub_pkg SHALL hold state enum (IDLE/RUN/DONE) and digit-count width function clog2-based.
REQ-030 Sub-module serial_digit_adder: combinational DIGIT_W-bit adder, inputs a, b, cin, outputs s, cout, cmsb (carry into top bit); instantiated once.
REQ-031 All outputs registered; no combinational path input to output.

Verification
REQ-032 WORD_W=8, DIGIT_W=1: a=8'h5A, b=8'h3C, add -> sum_o=8'h96, carry_o=0, ovf_o=1 (0 without macro), done_o 9 edges after start edge.
REQ-033 WORD_W=8, DIGIT_W=1: a=8'h10, b=8'h20, sub -> sum_o=8'hF0, carry_o=0, ovf_o=0; digit_o stream 0,0,0,0,1,1,1,1.
REQ-034 WORD_W=8, DIGIT_W=4: a=8'hFF, b=8'h01, add -> sum_o=8'h00, carry_o=1, ovf_o=0, done_o 3 edges after start.
REQ-035 start_i held high through RUN with changing a_i -> first operands' result only; second op starts in IDLE after DONE.
REQ-036 reset pulsed at 4th RUN cycle -> all outputs 0, no done_o; next start a=8'h01, b=8'h01 add -> sum_o=8'h02.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that indexes n digits; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT_W-bit adder slice; also exposes the carry into its top bit.
module serial_digit_adder #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               cmsb
);
  logic [DIGIT_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
  assign s    = full[DIGIT_W-1:0];
  assign cout = full[DIGIT_W];
  // Top sum bit is a^b^cin_top, so the carry into it falls out by XOR.
  assign cmsb = full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial A+B / A-B, DIGIT_W bits per clock, LSB first.
// Optional macro SERIAL_ADDSUB_OVF_EN enables signed overflow detection on ovf_o.
module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int DIGIT_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               sub_i,
  input  logic [WORD_W-1:0]  a_i,
  input  logic [WORD_W-1:0]  b_i,
  output logic               busy_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               digit_vld_o,
  output logic               done_o,
  output logic [WORD_W-1:0]  sum_o,
  output logic               carry_o,
  output logic               ovf_o
);
  localparam int N  = WORD_W / DIGIT_W;
  localparam int CW = cnt_w(N);

  if ((DIGIT_W < 1) || (WORD_W % DIGIT_W != 0)) begin : g_bad_digit_w
    $error("serial_addsub_unit: DIGIT_W must divide WORD_W exactly");
  end

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   a_q, b_q, res_q, res_d;
  logic                carry_q;
  logic [CW-1:0]       cnt_q;
  logic                last;
  logic [DIGIT_W-1:0]  dsum;
  logic                dcout, dcmsb;

  serial_digit_adder #(.DIGIT_W(DIGIT_W)) u_adder (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .cin  (carry_q),
    .s    (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  assign last  = (cnt_q == CW'(N - 1));
  // New digit enters at the MSB end; after N shifts the word is aligned.
  assign res_d = (res_q >> DIGIT_W) | (WORD_W'(dsum) << (WORD_W - DIGIT_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      digit_vld_o <= 1'b0;
      digit_o     <= '0;
      sum_o       <= '0;
      carry_o     <= 1'b0;
    end else begin
      busy_o      <= (state_d != IDLE);
      done_o      <= (state_q == RUN) && last;
      digit_vld_o <= (state_q == RUN);
      case (state_q)
        IDLE: if (start_i) begin
          // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
          a_q     <= a_i;
          b_q     <= sub_i ? ~b_i : b_i;
          carry_q <= sub_i;
          cnt_q   <= '0;
          res_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> DIGIT_W;
          b_q     <= b_q >> DIGIT_W;
          carry_q <= dcout;
          cnt_q   <= cnt_q + CW'(1);
          res_q   <= res_d;
          digit_o <= dsum;
          if (last) begin
            sum_o   <= res_d;
            carry_o <= dcout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          ovf_o <= 1'b0;
    else if ((state_q == RUN) && last)  ovf_o <= dcmsb ^ dcout;
  end
`else
  logic unused_cmsb;
  assign unused_cmsb = dcmsb;
  assign ovf_o       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: table vectors, random ops vs. arithmetic model, corner sequences.
module tb_serial_addsub_unit;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0, b = '0;

  logic       busy1, vld1, done1, cy1, ov1;
  logic [0:0] digit1;
  logic [7:0] sum1;
  logic       busy4, vld4, done4, cy4, ov4;
  logic [3:0] digit4;
  logic [7:0] sum4;

  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  serial_addsub_unit #(.WORD_W(8), .DIGIT_W(1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .sub_i(sub), .a_i(a), .b_i(b),
    .busy_o(busy1), .digit_o(digit1), .digit_vld_o(vld1), .done_o(done1),
    .sum_o(sum1), .carry_o(cy1), .ovf_o(ov1)
  );

  serial_addsub_unit #(.WORD_W(8), .DIGIT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start4), .sub_i(sub), .a_i(a), .b_i(b),
    .busy_o(busy4), .digit_o(digit4), .digit_vld_o(vld4), .done_o(done4),
    .sum_o(sum4), .carry_o(cy4), .ovf_o(ov4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Arithmetic reference: unsigned result mod 256, carry = no-borrow for sub, signed range check.
  function automatic void model(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                                output logic [7:0] sum, output logic cy, output logic ov);
    int ua, ub, sa, sb, r, sr;
    ua = ia; ub = ib;
    sa = $signed(ia); sb = $signed(ib);
    if (s) begin r = ua - ub; cy = (ua >= ub); sr = sa - sb; end
    else   begin r = ua + ub; cy = (r > 255);  sr = sa + sb; end
    sum = r[7:0];
    ov  = OVF_EN && ((sr > 127) || (sr < -128));
  endfunction

  // Runs one op on dut1 (sel=0) or dut4 (sel=1); returns results, latency in edges
  // counting the accepting edge as 1, and the reassembled digit stream.
  task automatic do_op(input int sel, input logic [7:0] ia, input logic [7:0] ib, input logic s,
                       output logic [7:0] sum, output logic cy, output logic ov,
                       output int lat, output logic [7:0] stream, output int nvld);
    int d;
    logic [3:0] dg;
    d = sel ? 4 : 1;
    sum = '0; cy = 1'b0; ov = 1'b0; stream = '0; nvld = 0; lat = 1;
    a = ia; b = ib; sub = s;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    chk("busy after start", sel ? busy4 : busy1, 1);
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? vld4 : vld1) begin
        dg = sel ? digit4 : {3'b000, digit1};
        stream = stream | (8'(dg) << (nvld * d));
        nvld++;
      end
      if (sel ? done4 : done1) begin
        sum = sel ? sum4 : sum1;
        cy  = sel ? cy4 : cy1;
        ov  = sel ? ov4 : ov1;
        break;
      end
    end
    @(posedge clk); #1;
    chk("done one cycle", sel ? done4 : done1, 0);
    chk("idle after done", sel ? busy4 : busy1, 0);
  endtask

  task automatic check_op(input string nm, input int sel,
                          input logic [7:0] sum, input logic cy, input logic ov, input int lat,
                          input logic [7:0] stream, input int nvld,
                          input logic [7:0] esum, input logic ecy, input logic eov);
    int n;
    n = sel ? 2 : 8;
    chk({nm, " sum"}, sum, esum);
    chk({nm, " carry"}, cy, ecy);
    chk({nm, " ovf"}, ov, eov);
    chk({nm, " latency"}, lat, n + 1);
    chk({nm, " stream"}, stream, esum);
    chk({nm, " nvld"}, nvld, n);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] sum;
    logic       cy, ov;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [7:0] rs, es, st;
    logic rc, ro, ec, eo;
    int lat, nv, ndone;
    logic [7:0] ra, rb;
    logic rsub;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset vld", vld1, 0);
    chk("reset sum", sum1, 0);
    chk("reset carry", cy1, 0);
    chk("reset ovf", ov1, 0);
    chk("reset busy4", busy4, 0);
    chk("reset digit4", digit4, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].s, rs, rc, ro, lat, st, nv);
      check_op($sformatf("tbl%0d", i), 0, rs, rc, ro, lat, st, nv,
               tbl[i].sum, tbl[i].cy, tbl[i].ov & OVF_EN);
    end

    do_op(1, 8'hFF, 8'h01, 1'b0, rs, rc, ro, lat, st, nv);
    check_op("d4 ff+01", 1, rs, rc, ro, lat, st, nv, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int sel;
      sel  = (i % 3 == 2) ? 1 : 0;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rsub = 1'($urandom);
      model(ra, rb, rsub, es, ec, eo);
      do_op(sel, ra, rb, rsub, rs, rc, ro, lat, st, nv);
      check_op($sformatf("rnd%0d", i), sel, rs, rc, ro, lat, st, nv, es, ec, eo);
    end

    // start held high through RUN while operands change underneath
    a = 8'h03; b = 8'h04; sub = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (lat < 40) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      lat++;
      if (done1) break;
    end
    chk("held start sum", sum1, 8'h07);
    chk("held start latency", lat, 9);
    @(posedge clk); #1;
    chk("held start ignored in done", busy1, 0);
    a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("second op accepted", busy1, 1);
    lat = 1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done1) break;
    end
    chk("second op sum", sum1, 8'h33);
    @(posedge clk); #1;

    // reset in the 4th RUN cycle aborts the op
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort busy", busy1, 0);
    chk("abort done", done1, 0);
    chk("abort vld", vld1, 0);
    chk("abort digit", digit1, 0);
    chk("abort sum", sum1, 0);
    chk("abort carry", cy1, 0);
    chk("abort ovf", ov1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done1 || busy1) ndone++;
    end
    chk("no done after abort", ndone, 0);
    reset = 1'b1; #2; reset = 1'b0;
    do_op(0, 8'h01, 8'h01, 1'b0, rs, rc, ro, lat, st, nv);
    check_op("post reset", 0, rs, rc, ro, lat, st, nv, 8'h02, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
